// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch I, load/store D) onto one req/ack memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
//
// state | meaning
// IDLE  | waiting for a request; winner and its access are latched on exit
// BUSY  | m_req high with latched access, waiting for m_ack
// DONE  | one-cycle ack to the granted requester, requests ignored
module mem_arbiter #(
   parameter int AW = 16,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_ack,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_ack,
   output logic          stall
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state_q, state_d;
   logic          grant_q, grant_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          we_q, we_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] i_rdata_q, i_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          win;

`ifdef MEM_ARB_RR_EN
   logic last_q;

   // On contention the requester not granted last wins (last_q: 0 = I, 1 = D).
   assign win = d_req & (~i_req | ~last_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_q <= 1'b0;
      end else if (state_q == IDLE && (i_req || d_req)) begin
         last_q <= win;
      end
   end
`else
   assign win = d_req;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         grant_q   <= 1'b0;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         addr_q    <= addr_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      addr_d    = addr_q;
      we_d      = we_q;
      wdata_d   = wdata_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               state_d = BUSY;
               grant_d = win;
               addr_d  = win ? d_addr : i_addr;
               we_d    = win & d_we;
               wdata_d = win ? d_wdata : '0;
            end
         end
         BUSY: begin
            if (m_ack) begin
               state_d = DONE;
               if (!we_q) begin
                  if (grant_q) d_rdata_d = m_rdata;
                  else         i_rdata_d = m_rdata;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign m_req   = (state_q == BUSY);
   assign m_we    = we_q;
   assign m_addr  = addr_q;
   assign m_wdata = wdata_q;
   assign i_ack   = (state_q == DONE) & ~grant_q;
   assign d_ack   = (state_q == DONE) &  grant_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign stall   = (i_req | d_req) & ~(i_ack | d_ack);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the core's single-port memory between instruction fetch and load/store accesses from the datapath. Holds each granted request in registers, drives the memory port with a req/ack handshake of any latency, and returns read data plus a one-cycle acknowledge to the winning requester. A `stall` output freezes the datapath while any access is outstanding.

## Interface
Parameters:
- `AW`, 16, address width
- `DW`, 16, data width

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `i_req`  in  1  fetch request, held until `i_ack`
- `i_addr`  in  AW  fetch address
- `i_rdata`  out  DW  fetch read data, registered
- `i_ack`  out  1  fetch done, 1-cycle pulse
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_rdata`  out  DW  load data, registered
- `d_ack`  out  1  data done, 1-cycle pulse
- `m_req`  out  1  memory request
- `m_we`  out  1  memory write enable
- `m_addr`  out  AW  memory address
- `m_wdata`  out  DW  memory write data
- `m_rdata`  in  DW  memory read data, valid with `m_ack`
- `m_ack`  in  1  memory done, sampled while `m_req` = 1
- `stall`  out  1  datapath stall

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any request is pending, select the winner. Latch `grant` (0 = I, 1 = D), address, `we` (forced 0 for I) and wdata into registers, then go to BUSY. Otherwise stay in IDLE.
- Arbitration, default: D has fixed priority over I.
- BUSY: `m_req` = 1, and `m_we`/`m_addr`/`m_wdata` come from the latched registers and stay stable. When `m_ack` = 1:
  - on a read, capture `m_rdata` into `i_rdata` or `d_rdata` per `grant`;
  - go to DONE.
- DONE: assert `i_ack` or `d_ack` per `grant` for exactly 1 cycle. Ignore all requests. Go to IDLE.
- Writes leave both rdata registers unchanged. Each rdata register holds its value until the next read granted to that port.
- `m_ack` outside BUSY is ignored.
- A requester dropping `req` during BUSY does not abort the access. The access completes, and its ack still pulses.
- Requesters must deassert `req` on the edge where they sample `ack`. A `req` still high in the IDLE cycle after DONE is treated as a new request.
- `stall` = (`i_req` | `d_req`) & ~(`i_ack` | `d_ack`), combinational.

## Timing
- Reset (`reset` = 0, asynchronous) forces:
  - state IDLE, `m_req` = 0, both acks = 0;
  - `i_rdata` = `d_rdata` = 0;
  - latched registers = 0; last-grant = I.
- Reset during BUSY aborts the memory access immediately: `m_req` falls without waiting for `m_ack`, and no ack is issued.
- Minimum latency with same-cycle `m_ack`:
  - `req` sampled at edge N;
  - `m_req` high in cycle N+1;
  - ack high in cycle N+2;
  - IDLE again at N+3.
- Back-to-back throughput is therefore 1 access per 3 cycles. Each cycle of `m_ack` wait adds 1 cycle.
- Memory outputs change only on the IDLE→BUSY transition.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A last-grant register updates on every IDLE→BUSY transition.
  - When both requests are pending in IDLE, the requester not granted last wins.
  - A single pending request always wins.
- Undefined: fixed D-over-I priority, and no last-grant register is present.

## Test plan
- Reset, then a lone fetch: `i_req`=1, `i_addr`=0x0010, memory returns 0xABCD with `m_ack` in the first BUSY cycle → `m_req` high in cycle 1, `i_ack` pulse in cycle 2, `i_rdata`=0xABCD, `d_rdata`=0.
- Store with 3-cycle memory wait: `d_we`=1, `d_addr`=0x0100, `d_wdata`=0x1234 → `m_we`=1 and address/data stable for 4 BUSY cycles, `d_ack` 1 cycle after `m_ack`, `d_rdata` unchanged.
- Simultaneous `i_req` and `d_req`, both reads, held continuously:
  - without the macro → D is granted first, then I; each gets exactly one ack;
  - with `MEM_ARB_RR_EN` after a prior D grant → I first.
- `m_ack` pulsed in IDLE and DONE → no state change, no ack, no rdata update.
- `reset` asserted mid-BUSY → `m_req`, acks and rdata are 0 asynchronously, no ack after reset is released, and a fresh request after release completes normally.
- `stall` check: high from `i_req` rise until the `i_ack` cycle, low in that cycle and while no requests are pending.
